// File: rtl/fp_pkg.sv
// fp_pkg: shared types and constants for the FP multiplier slice.
//   fp_class_e   operand class after unpack (subnormals fold into FP_ZERO)
//   FLG_*        bit positions inside the 4-bit flags word
//   fp_bias      exponent bias for a given exponent width
//   fp_qnan      canonical quiet NaN, returned LSB-aligned in a 128-bit word
package fp_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // {0, all-ones exponent, 1, zeros}; caller slices [W-1:0]
  function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
    logic [127:0] r;
    r = '0;
    for (int i = man_w - 1; i < man_w + exp_w; i++) r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// fp_unpack: combinational field split and classification of one operand.
//   x     packed operand {sign, exponent, fraction}
//   sign  sign bit
//   ex    biased exponent (forced to 0 for flushed subnormals)
//   sig   significand with hidden bit (0 for zero/subnormal)
//   cls   FP_ZERO / FP_NORM / FP_INF / FP_NAN
//   snan  operand is a signalling NaN (fraction MSB clear)
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  output logic                 sign,
  output logic [EXP_W-1:0]     ex,
  output logic [MAN_W:0]       sig,
  output fp_class_e            cls,
  output logic                 snan
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] f;

  assign e = x[EXP_W+MAN_W-1:MAN_W];
  assign f = x[MAN_W-1:0];

  always_comb begin
    sign = x[EXP_W+MAN_W];
    ex   = e;
    sig  = {1'b1, f};
    cls  = FP_NORM;
    snan = 1'b0;
    if (e == '1) begin
      if (f == '0) begin
        cls = FP_INF;
      end else begin
        cls  = FP_NAN;
        snan = ~f[MAN_W-1];
      end
    end else if (e == '0) begin
      // zero and subnormal both become signed zero
      cls = FP_ZERO;
      ex  = '0;
      sig = '0;
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined IEEE-754 multiplier with valid/ready.
//   S1 unpack/classify + special-case resolution
//   S2 significand product, exponent sum, sign
//   S3 normalize, round, range check, pack (registered output)
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b)
//   out_valid/out_ready result handshake (result, flags)
//   flags               {invalid, overflow, underflow, inexact}
// Build option: define FP_MUL_RNE_EN for round-to-nearest-even,
// otherwise the result is truncated (round toward zero).
// Any output stall freezes every stage, so in_ready = ~stall.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int STAGES = 3;
  localparam int PW     = 2 * MAN_W + 2;
  localparam int XW     = EXP_W + 2;

  localparam logic [127:0]   QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]   QNAN      = QNAN_WIDE[W-1:0];
  localparam logic [XW-1:0]  BIAS_X    = XW'(fp_bias(EXP_W));
  localparam logic [XW-1:0]  EXP_MAX   = XW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic             sa;
    logic             sb;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MAN_W:0]   ma;
    logic [MAN_W:0]   mb;
    logic             spec;
    logic [W-1:0]     spec_res;
    logic [3:0]       spec_flg;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [XW-1:0]    ex;     // signed exponent, carried as raw bits
    logic [PW-1:0]    prod;
    logic             spec;
    logic [W-1:0]     spec_res;
    logic [3:0]       spec_flg;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            stall;
  logic            accept;
  s1_t             s1, s1_d;
  s2_t             s2, s2_d;

  assign out_valid = vld_pipe[STAGES];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;

  // ---------------- S1: unpack / classify ----------------
  logic             sa, sb, sn_a, sn_b;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0]   ma, mb;
  fp_class_e        ca, cb;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .x(a), .sign(sa), .ex(ea), .sig(ma), .cls(ca), .snan(sn_a)
  );
  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .x(b), .sign(sb), .ex(eb), .sig(mb), .cls(cb), .snan(sn_b)
  );

  always_comb begin
    s1_d          = '0;
    s1_d.sa       = sa;
    s1_d.sb       = sb;
    s1_d.ea       = ea;
    s1_d.eb       = eb;
    s1_d.ma       = ma;
    s1_d.mb       = mb;
    // NaN outranks inf*0, which outranks inf, which outranks zero
    if (ca == FP_NAN || cb == FP_NAN) begin
      s1_d.spec              = 1'b1;
      s1_d.spec_res          = QNAN;
      s1_d.spec_flg[FLG_INV] = (ca == FP_NAN && sn_a) || (cb == FP_NAN && sn_b);
    end else if ((ca == FP_INF && cb == FP_ZERO) || (ca == FP_ZERO && cb == FP_INF)) begin
      s1_d.spec              = 1'b1;
      s1_d.spec_res          = QNAN;
      s1_d.spec_flg[FLG_INV] = 1'b1;
    end else if (ca == FP_INF || cb == FP_INF) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ca == FP_ZERO || cb == FP_ZERO) begin
      s1_d.spec     = 1'b1;
      s1_d.spec_res = {sa ^ sb, {(W-1){1'b0}}};
    end
  end

  // ---------------- S2: multiply ----------------
  always_comb begin
    s2_d          = '0;
    s2_d.sign     = s1.sa ^ s1.sb;
    s2_d.ex       = $unsigned($signed({2'b00, s1.ea}) + $signed({2'b00, s1.eb})
                              - $signed(BIAS_X));
    s2_d.prod     = {{(MAN_W+1){1'b0}}, s1.ma} * {{(MAN_W+1){1'b0}}, s1.mb};
    s2_d.spec     = s1.spec;
    s2_d.spec_res = s1.spec_res;
    s2_d.spec_flg = s1.spec_flg;
  end

  // ---------------- S3: normalize / round / pack ----------------
  logic [PW-1:0]      pn;
  logic               msb, guard, sticky, inc, carry;
  logic [MAN_W:0]     sig;
  logic [MAN_W+1:0]   sig_r;
  logic [MAN_W-1:0]   frac;
  logic signed [XW-1:0] e_n, e_r;
  logic [W-1:0]       res_d;
  logic [3:0]         flg_d;

  always_comb begin
    msb    = s2.prod[PW-1];
    // product lies in [1,4): align so the leading one sits at the MSB
    pn     = msb ? s2.prod : (s2.prod << 1);
    e_n    = $signed(s2.ex) + $signed({{(XW-1){1'b0}}, msb});
    sig    = pn[PW-1:MAN_W+1];
    guard  = pn[MAN_W];
    sticky = |pn[MAN_W-1:0];
`ifdef FP_MUL_RNE_EN
    inc    = guard & (sticky | sig[0]);
`else
    inc    = 1'b0;
`endif
    sig_r  = {1'b0, sig} + {{(MAN_W+1){1'b0}}, inc};
    carry  = sig_r[MAN_W+1];
    // on carry-out the significand is exactly 2.0, so the fraction is zero
    frac   = carry ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
    e_r    = e_n + $signed({{(XW-1){1'b0}}, carry});

    res_d  = {s2.sign, e_r[EXP_W-1:0], frac};
    flg_d  = '0;
    flg_d[FLG_INX] = guard | sticky;
    if (s2.spec) begin
      res_d = s2.spec_res;
      flg_d = s2.spec_flg;
    end else if (!e_r[XW-1] && e_r >= $signed(EXP_MAX)) begin
      res_d          = {s2.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_d[FLG_OVF] = 1'b1;
      flg_d[FLG_INX] = 1'b1;
    end else if (e_r[XW-1] || e_r == '0) begin
      // both operands were normal, so the true value is never zero here
      res_d          = {s2.sign, {(W-1){1'b0}}};
      flg_d[FLG_UNF] = 1'b1;
      flg_d[FLG_INX] = 1'b1;
    end
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2       <= '0;
      result   <= '0;
      flags    <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept)      s1 <= s1_d;
      if (vld_pipe[1]) s2 <= s2_d;
      if (vld_pipe[2]) begin
        result <= res_d;
        flags  <= flg_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed vector table plus backpressure and
// mid-stream reset sequences for fp_mul_pipe at default widths.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  int total = 0;
  int bad   = 0;

  fp_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int lat;
    a = vecs[i].a; b = vecs[i].b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("vec%0d latency", i), 64'(lat), 64'd3);
    chk($sformatf("vec%0d result", i), 64'(result), 64'(vecs[i].res));
    chk($sformatf("vec%0d flags", i), 64'(flags), 64'(vecs[i].flg));
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] q[$];
    logic [35:0] held;
    logic        held_vld;
    int sent, got, first_low, low_cnt, stale, unexp;

    //            a             b             result        flags
    vecs[0]  = {32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000};
`ifdef FP_MUL_RNE_EN
    vecs[1]  = {32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0001};
`else
    vecs[1]  = {32'h3FC00001, 32'h3FC00001, 32'h40100001, 4'b0001};
`endif
    vecs[2]  = {32'h7F000000, 32'h40000000, 32'h7F800000, 4'b0101};
    vecs[3]  = {32'h7F800000, 32'h80000000, 32'h7FC00000, 4'b1000};
    vecs[4]  = {32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011};
    vecs[5]  = {32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000};
    vecs[6]  = {32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000};
    vecs[7]  = {32'h7FC00000, 32'h00000000, 32'h7FC00000, 4'b0000};
    vecs[8]  = {32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};
    vecs[9]  = {32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000};
    vecs[10] = {32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000};
    vecs[11] = {32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000};
    vecs[12] = {32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001};
    vecs[13] = {32'h7F800000, 32'h7F800000, 32'h7F800000, 4'b0000};
    vecs[14] = {32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000};
    vecs[15] = {32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000};
    vecs[16] = {32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000};

    // reset state
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    chk("rst flags", 64'(flags), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < NV; i++) run_vec(i);

    // backpressure: 5 pairs, consumer blocked for the first 6 cycles
    sent = 0; got = 0; first_low = -1; low_cnt = 0; held_vld = 1'b0; unexp = 0;
    held = '0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      in_valid  = (sent < 5);
      a         = vecs[sent].a;
      b         = vecs[sent].b;
      out_ready = (cyc >= 6);
      #1;
      if (!in_ready) begin
        low_cnt++;
        if (first_low < 0) first_low = cyc;
      end
      if (held_vld) begin
        chk($sformatf("bp hold valid c%0d", cyc), 64'(out_valid), 64'd1);
        chk($sformatf("bp hold data c%0d", cyc), 64'({result, flags}), 64'(held));
        held_vld = 1'b0;
      end
      if (out_valid) begin
        if (q.size() == 0) unexp++;
        else if (out_ready) begin
          chk($sformatf("bp out%0d", got), 64'({result, flags}), 64'(q.pop_front()));
          got++;
        end else begin
          held     = {result, flags};
          held_vld = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({vecs[sent].res, vecs[sent].flg});
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp delivered", 64'(got), 64'd5);
    chk("bp in_ready first low", 64'(first_low), 64'd3);
    chk("bp in_ready low cycles", 64'(low_cnt), 64'd3);
    repeat (3) begin
      if (out_valid) unexp++;
      @(posedge clk); #1;
    end
    chk("bp extra outputs", 64'(unexp), 64'd0);

    // reset with two operations in flight
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; a = vecs[0].a; b = vecs[0].b;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid rst out_valid", 64'(out_valid), 64'd0);
    chk("mid rst result", 64'(result), 64'd0);
    chk("mid rst in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("mid rst stale", 64'(stale), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, three-stage pipelined IEEE-754 floating-point multiplier with valid/ready handshaking. It extends the team's combinational single-precision multiplier with:
- configurable exponent and mantissa widths;
- correct handling of the special operands zero, infinity and NaN;
- rounding, status flags and backpressure.

It sits in the arithmetic datapath of the SD122 somadores set, feeding FP accumulators and adders.

## Interface
- `EXP_W`, default 8: exponent field width; bias = 2^(EXP_W-1)-1.
- `MAN_W`, default 23: stored fraction width, excluding the hidden bit.
- `W`, derived = 1+EXP_W+MAN_W: operand and result width. Do not override.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block accepts the pair this cycle.
- `a`  in  W  multiplicand.
- `b`  in  W  multiplier.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result this cycle.
- `result`  out  W  product.
- `flags`  out  4  {invalid, overflow, underflow, inexact}, aligned with `result`.

## Operation
- **S1, unpack/classify**
  - Split each operand into sign, exponent and fraction.
  - Classify each operand as zero, subnormal, normal, inf or NaN.
  - Subnormal inputs are treated as signed zero (flush-to-zero).
- **S2, multiply**
  - Compute the (MAN_W+1)×(MAN_W+1) significand product, 2*MAN_W+2 bits wide.
  - Compute the signed exponent sum ea+eb-bias at EXP_W+2 bits, so no wrap occurs.
  - Sign = sa^sb.
- **S3, normalize/round/pack**
  - If the product MSB is set, shift right by 1 and add 1 to the exponent.
  - Guard = first dropped bit; sticky = OR of all remaining dropped bits.
  - Round (see Configuration). A rounding carry-out of the significand shifts right by 1 and adds 1 to the exponent.
  - If the final exponent ≥ 2^EXP_W-1: result = signed inf, set overflow and inexact.
  - If the final exponent ≤ 0: result = signed zero, set underflow, and set inexact if the value was nonzero.
- **Special cases**, resolved in S1 and carried down the pipe; they override the arithmetic result:
  - Any NaN operand → canonical qNaN {0, all-ones exponent, 1, zeros}. Flags 0, except invalid when that NaN's fraction MSB = 0 (sNaN).
  - inf × zero → canonical qNaN, invalid = 1.
  - inf × (finite nonzero or inf) → signed inf, flags 0.
  - zero × finite → signed zero, flags 0.
- inexact = guard | sticky for normal results.

## Timing
- Latency: 3 cycles from input acceptance to `out_valid`, with no stalls. Throughput: 1 result per cycle.
- Each stage has a valid bit. Global stall = out_valid & ~out_ready; while stalled, every stage register holds.
- in_ready = ~stall. This is combinational from out_ready and registered out_valid.
- A pair is accepted only on in_valid & in_ready. Data present while in_ready = 0 is ignored, not latched.
- `result` and `flags` stay stable while out_valid & ~out_ready.
- Ordering is strictly FIFO. Capacity is 3 in flight.
- Reset:
  - all stage valids, out_valid, result and flags = 0;
  - in_ready = 1 in the first cycle after reset;
  - in-flight operations are discarded.
- An acceptance and a drain in the same cycle are both legal. The pipe advances normally.

## Configuration
- `FP_MUL_RNE_EN` defined: round-to-nearest-ties-to-even. Increment when guard & (sticky | lsb).
- `FP_MUL_RNE_EN` undefined: round toward zero (truncate). The inexact flag is still computed.
- Latency and interface are identical in both builds.

## Structure
- Shared package `fp_pkg`:
  - class enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN};
  - flag bit indices;
  - bias and qNaN constant functions of EXP_W/MAN_W.
- One sub-module, `fp_unpack`: combinational field split and classification, instantiated per operand in S1.
- The multiply and S3 logic live in `fp_mul_pipe`.

## Test plan
All vectors use default widths.
- **Basic product:** 0x3FC00000 × 0x40000000 → 0x40400000, flags 0000, out_valid exactly 3 cycles after acceptance.
- **Rounding:** 0x3FC00001 × 0x3FC00001 → with RNE 0x40100002, without 0x40100001; inexact = 1 in both builds.
- **Overflow/invalid:**
  - 0x7F000000 × 0x40000000 → 0x7F800000, overflow = 1, inexact = 1.
  - 0x7F800000 × 0x80000000 → 0x7FC00000, invalid = 1.
- **Underflow/FTZ:**
  - 0x00800000 × 0x3F000000 → 0x00000000, underflow = 1.
  - 0x00000001 × 0x3F800000 → 0x00000000, flags 0000.
- **Backpressure:** stream 5 pairs with out_ready = 0 for 6 cycles, then 1.
  - in_ready drops once 3 are in flight.
  - Every accepted result is delivered once, in order, stable during the stall.
- **Reset mid-stream:** assert rst with 2 in flight.
  - Next cycle: out_valid = 0, result = 0, in_ready = 1.
  - No stale result appears afterwards.
